// File: rtl/fft_delay_commutator.sv
// Pairs x[n] with x[n+DEPTH] for the radix-2 butterfly of one pipelined FFT stage.
// Optional block realignment via sync_in/sync_err when DC_SYNC_EN is defined.
module fft_delay_commutator #(
    parameter int unsigned NBITS = 10,
    parameter int unsigned DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*NBITS-1:0] din,
    input  logic               din_valid,
`ifdef DC_SYNC_EN
    input  logic               sync_in,
    output logic               sync_err,
`endif
    output logic [2*NBITS-1:0] pair_up,
    output logic [2*NBITS-1:0] pair_down,
    output logic               pair_valid,
    output logic               sync_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] CntLast = AW'(DEPTH - 1);

    typedef enum logic {
        StFill,
        StPair
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       w_cnt_next;
    logic                w_mem_we;
    logic [AW-1:0]       w_mem_addr;
    logic                w_sync_hit;
    logic                w_pair_fire;
    logic [2*NBITS-1:0]  r_mem [DEPTH];
    logic [2*NBITS-1:0]  r_pair_up;
    logic [2*NBITS-1:0]  r_pair_down;
    logic                r_pair_valid;
    logic                r_sync_out;

`ifdef DC_SYNC_EN
    logic r_sync_err;
    assign w_sync_hit = din_valid & sync_in;
    assign sync_err   = r_sync_err;
`else
    assign w_sync_hit = 1'b0;
`endif

    assign w_pair_fire = din_valid && (r_state == StPair) && !w_sync_hit;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_cnt;
        if (w_sync_hit) begin
            // Realign: this sample becomes position 0 of a fresh block.
            w_mem_we     = 1'b1;
            w_mem_addr   = '0;
            w_cnt_next   = AW'(1);
            w_state_next = StFill;
        end else if (din_valid) begin
            w_mem_we   = (r_state == StFill);
            w_cnt_next = r_cnt + AW'(1);
            if (r_cnt == CntLast) begin
                w_cnt_next   = '0;
                w_state_next = (r_state == StFill) ? StPair : StFill;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFill;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Sample buffer carries no reset; its contents are rewritten before use.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair_up    <= '0;
            r_pair_down  <= '0;
            r_pair_valid <= 1'b0;
            r_sync_out   <= 1'b0;
        end else begin
            r_pair_valid <= w_pair_fire;
            r_sync_out   <= w_pair_fire && (r_cnt == '0);
            if (w_pair_fire) begin
                r_pair_up   <= r_mem[r_cnt];
                r_pair_down <= din;
            end
        end
    end

`ifdef DC_SYNC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else if (w_sync_hit && !((r_state == StFill) && (r_cnt == '0))) begin
            r_sync_err <= 1'b1;
        end
    end
`endif

    assign pair_up    = r_pair_up;
    assign pair_down  = r_pair_down;
    assign pair_valid = r_pair_valid;
    assign sync_out   = r_sync_out;

endmodule

// File: tb/tb_fft_delay_commutator.sv
// Scoreboard bench for fft_delay_commutator (DEPTH=4, NBITS=10); sync tests need DC_SYNC_EN.
module tb_fft_delay_commutator;

    localparam int unsigned NBITS = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 2 * NBITS;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic [W-1:0] pair_up;
    logic [W-1:0] pair_down;
    logic         pair_valid;
    logic         sync_out;
`ifdef DC_SYNC_EN
    logic         sync_in;
    logic         sync_err;
`endif

    fft_delay_commutator #(
        .NBITS(NBITS),
        .DEPTH(DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
`ifdef DC_SYNC_EN
        .sync_in   (sync_in),
        .sync_err  (sync_err),
`endif
        .pair_up   (pair_up),
        .pair_down (pair_down),
        .pair_valid(pair_valid),
        .sync_out  (sync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: position within a 2*DEPTH block, first-half buffer, held outputs.
    int           m_pos;
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] m_last_up;
    logic [W-1:0] m_last_down;
    logic         m_exp_err;
    logic [2*W:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [W-1:0] smp(input int k);
        logic [NBITS-1:0] re;
        logic [NBITS-1:0] im;
        re = NBITS'(k);
        im = NBITS'(-k);
        return {re, im};
    endfunction

    task automatic model_reset();
        m_pos       = 0;
        m_last_up   = '0;
        m_last_down = '0;
        m_exp_err   = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle, advance the model, then check outputs 1 ns after the edge.
    task automatic drive(input logic v, input int k, input logic s);
        logic         fire;
        logic         hit;
        logic [2*W:0] e;
        fire = 1'b0;
        hit  = 1'b0;
        din       = v ? smp(k) : '0;
        din_valid = v;
`ifdef DC_SYNC_EN
        sync_in = s;
        hit     = v && s;
`endif
        if (hit) begin
            if (m_pos != 0) m_exp_err = 1'b1;
            m_mem[0] = smp(k);
            m_pos    = 1;
        end else if (v) begin
            if (m_pos < DEPTH) begin
                m_mem[m_pos] = smp(k);
            end else begin
                sb_q.push_back({m_mem[m_pos-DEPTH], smp(k), m_pos == DEPTH});
                fire = 1'b1;
            end
            m_pos = (m_pos + 1) % (2 * DEPTH);
        end
        @(posedge clk);
        #1;
        check("pair_valid", pair_valid, fire);
        if (fire) begin
            e = sb_q.pop_front();
            check("pair_up", pair_up, e[2*W:W+1]);
            check("pair_down", pair_down, e[W:1]);
            check("sync_out", sync_out, e[0]);
            m_last_up   = e[2*W:W+1];
            m_last_down = e[W:1];
        end else begin
            check("hold_up", pair_up, m_last_up);
            check("hold_down", pair_down, m_last_down);
        end
`ifdef DC_SYNC_EN
        check("sync_err", sync_err, m_exp_err);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, pair_valid, 1'b0);
        check({tag, "_up"}, pair_up, '0);
        check({tag, "_down"}, pair_down, '0);
        check({tag, "_sync"}, sync_out, 1'b0);
`ifdef DC_SYNC_EN
        check({tag, "_err"}, sync_err, 1'b0);
`endif
    endtask

    // Assert reset asynchronously mid-cycle and release it away from the edge.
    task automatic do_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
`ifdef DC_SYNC_EN
        sync_in = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // One block
        for (int k = 0; k < 8; k++) drive(1'b1, k, 1'b0);
        drive(1'b0, 0, 1'b0);
        // Two back-to-back blocks
        for (int k = 0; k < 16; k++) drive(1'b1, k, 1'b0);
        // Idle gap in the second half
        for (int k = 0; k < 6; k++) drive(1'b1, k, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0);
        for (int k = 6; k < 8; k++) drive(1'b1, k, 1'b0);
        drive(1'b0, 0, 1'b0);
        // Reset mid-block, then replay
        for (int k = 0; k < 6; k++) drive(1'b1, k, 1'b0);
        do_reset("midrst");
        for (int k = 0; k < 8; k++) drive(1'b1, k, 1'b0);
        drive(1'b0, 0, 1'b0);
`ifdef DC_SYNC_EN
        // Misaligned sync forces realignment and sets the sticky error
        do_reset("rst5");
        for (int k = 0; k < 3; k++) drive(1'b1, k, 1'b0);
        drive(1'b1, 10, 1'b1);
        for (int k = 11; k < 18; k++) drive(1'b1, k, 1'b0);
        drive(1'b0, 0, 1'b0);
        // Sync at a true boundary leaves the error clear
        do_reset("rst6");
        drive(1'b1, 0, 1'b1);
        for (int k = 1; k < 8; k++) drive(1'b1, k, 1'b0);
        drive(1'b0, 0, 1'b0);
`endif
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
